// File: rtl/tb_apb_pkg.sv
// Shared types and defaults for the APB command-master model and its bench.
// Holds the FSM encoding, default bus widths and the command record.
package tb_apb_pkg;

   localparam int unsigned APB_ADDR_W = 32;
   localparam int unsigned APB_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_e;

   typedef struct packed {
      logic                  write;
      logic [APB_ADDR_W-1:0] addr;
      logic [APB_DATA_W-1:0] wdata;
   } apb_cmd_t;

   // Width able to hold 0..limit, never narrower than one bit.
   function automatic int unsigned wait_cnt_w(input int unsigned limit);
      int unsigned w;
      w = $clog2(limit + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/tb_apb_wait_timer.sv
// Per-transfer ACCESS wait counter with a compare-equal timeout flag.
// A LIMIT of 0 disables both counting and the flag.
module tb_apb_wait_timer #(
   parameter int unsigned LIMIT = 256,
   parameter int unsigned CNT_W = 9
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_next;

   // cnt_next is the ordinal of the current ACCESS cycle: 1 on the first one.
   always_comb begin
      cnt_next = cnt_q + CNT_W'(1);
      cnt_d    = cnt_q;
      if (i_clr) begin
         cnt_d = '0;
      end else if (i_en && (LIMIT != 0)) begin
         cnt_d = cnt_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_expired = (LIMIT != 0) && i_en && (cnt_next == LIMIT_V);

endmodule

// File: rtl/tb_apb_cmd_master.sv
// Converts a valid/ready command stream into single APB3 transfers and
// returns read data or a timeout error on a valid/ready response channel.
module tb_apb_cmd_master
   import tb_apb_pkg::*;
#(
   parameter int unsigned ADDR_W         = APB_ADDR_W,
   parameter int unsigned DATA_W         = APB_DATA_W,
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int unsigned CNT_W          = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_cmd_valid,
   output logic              o_cmd_ready,
   input  logic              i_cmd_write,
   input  logic [ADDR_W-1:0] i_cmd_addr,
   input  logic [DATA_W-1:0] i_cmd_wdata,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [DATA_W-1:0] o_rsp_rdata,
   output logic              o_rsp_err,
   output logic              o_psel,
   output logic              o_penable,
   output logic              o_pwrite,
   output logic [ADDR_W-1:0] o_paddr,
   output logic [DATA_W-1:0] o_pwdata,
   input  logic [DATA_W-1:0] i_prdata,
   input  logic              i_pready,
   output logic [CNT_W-1:0]  o_txn_cnt
);

   localparam int unsigned WAIT_W = wait_cnt_w(TIMEOUT_CYCLES);

   apb_state_e        state_q, state_d;
   logic              write_q, write_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  txn_cnt_q, txn_cnt_d;
   logic              accept;
   logic              timed_out;

   assign accept = (state_q == IDLE) && i_cmd_valid;

   tb_apb_wait_timer #(
      .LIMIT (TIMEOUT_CYCLES),
      .CNT_W (WAIT_W)
   ) u_wait_timer (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (accept),
      .i_en      (state_q == ACCESS),
      .o_expired (timed_out)
   );

   always_comb begin
      state_d   = state_q;
      write_d   = write_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      txn_cnt_d = txn_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (i_cmd_valid) begin
               write_d = i_cmd_write;
               addr_d  = i_cmd_addr;
               wdata_d = i_cmd_wdata;
               state_d = SETUP;
            end
         end
         SETUP: begin
            state_d = ACCESS;
         end
         ACCESS: begin
            // A slave answering on the timeout cycle still completes normally.
            if (i_pready) begin
               rdata_d = write_q ? '0 : i_prdata;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (timed_out) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            if (i_rsp_ready) begin
               txn_cnt_d = txn_cnt_q + CNT_W'(1);
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         write_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         txn_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         write_q   <= write_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         txn_cnt_q <= txn_cnt_d;
      end
   end

   // Address/data/direction stay on the bus after a transfer; only the strobes drop.
   assign o_cmd_ready = (state_q == IDLE);
   assign o_psel      = (state_q == SETUP) || (state_q == ACCESS);
   assign o_penable   = (state_q == ACCESS);
   assign o_pwrite    = write_q;
   assign o_paddr     = addr_q;
   assign o_pwdata    = wdata_q;
   assign o_rsp_valid = (state_q == RESP);
   assign o_rsp_rdata = rdata_q;
   assign o_rsp_err   = err_q;
   assign o_txn_cnt   = txn_cnt_q;

endmodule

// File: tb/tb_tb_apb_cmd_master.sv
// Directed bench for the APB command master: zero-wait, wait states,
// timeout boundary, response backpressure, async reset and back-to-back.
module tb_tb_apb_cmd_master;
   import tb_apb_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_cmd_valid;
   logic        o_cmd_ready;
   logic        i_cmd_write;
   logic [31:0] i_cmd_addr;
   logic [31:0] i_cmd_wdata;
   logic        o_rsp_valid;
   logic        i_rsp_ready;
   logic [31:0] o_rsp_rdata;
   logic        o_rsp_err;
   logic        o_psel;
   logic        o_penable;
   logic        o_pwrite;
   logic [31:0] o_paddr;
   logic [31:0] o_pwdata;
   logic [31:0] i_prdata;
   logic        i_pready;
   logic [15:0] o_txn_cnt;

   int n_vec  = 0;
   int n_miss = 0;

   tb_apb_cmd_master #(
      .ADDR_W         (32),
      .DATA_W         (32),
      .TIMEOUT_CYCLES (8),
      .CNT_W          (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_cmd_valid (i_cmd_valid),
      .o_cmd_ready (o_cmd_ready),
      .i_cmd_write (i_cmd_write),
      .i_cmd_addr  (i_cmd_addr),
      .i_cmd_wdata (i_cmd_wdata),
      .o_rsp_valid (o_rsp_valid),
      .i_rsp_ready (i_rsp_ready),
      .o_rsp_rdata (o_rsp_rdata),
      .o_rsp_err   (o_rsp_err),
      .o_psel      (o_psel),
      .o_penable   (o_penable),
      .o_pwrite    (o_pwrite),
      .o_paddr     (o_paddr),
      .o_pwdata    (o_pwdata),
      .i_prdata    (i_prdata),
      .i_pready    (i_pready),
      .o_txn_cnt   (o_txn_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put_cmd(input apb_cmd_t c);
      i_cmd_valid = 1'b1;
      i_cmd_write = c.write;
      i_cmd_addr  = c.addr;
      i_cmd_wdata = c.wdata;
   endtask

   initial begin : stim
      int n_acc;
      int ns;
      int setup_cyc[3];
      logic [15:0] cnt_before;

      rst = 1'b1;
      i_cmd_valid = 1'b0; i_cmd_write = 1'b0; i_cmd_addr = '0; i_cmd_wdata = '0;
      i_rsp_ready = 1'b0; i_prdata = '0; i_pready = 1'b0;
      tick(); tick();

      // reset state
      chk("rst_cmd_ready", o_cmd_ready, 1);
      chk("rst_psel", o_psel, 0);
      chk("rst_penable", o_penable, 0);
      chk("rst_rsp_valid", o_rsp_valid, 0);
      chk("rst_paddr", o_paddr, 0);
      chk("rst_pwdata", o_pwdata, 0);
      chk("rst_rdata", o_rsp_rdata, 0);
      chk("rst_txn_cnt", o_txn_cnt, 0);
      rst = 1'b0;
      tick();

      // zero-wait write
      put_cmd('{write: 1'b1, addr: 32'h0000_0010, wdata: 32'hA5A5_0001});
      i_pready = 1'b1; i_prdata = 32'h1234_5678; i_rsp_ready = 1'b1;
      chk("w0_cmd_ready", o_cmd_ready, 1);
      tick();
      i_cmd_valid = 1'b0;
      chk("w0_setup_psel", o_psel, 1);
      chk("w0_setup_penable", o_penable, 0);
      chk("w0_pwrite", o_pwrite, 1);
      chk("w0_paddr", o_paddr, 32'h0000_0010);
      chk("w0_pwdata", o_pwdata, 32'hA5A5_0001);
      tick();
      chk("w0_access_psel", o_psel, 1);
      chk("w0_access_penable", o_penable, 1);
      tick();
      chk("w0_rsp_valid", o_rsp_valid, 1);
      chk("w0_rsp_err", o_rsp_err, 0);
      chk("w0_rsp_rdata", o_rsp_rdata, 0);
      chk("w0_rsp_psel", o_psel, 0);
      tick();
      i_rsp_ready = 1'b0;
      chk("w0_rsp_dropped", o_rsp_valid, 0);
      chk("w0_txn_cnt", o_txn_cnt, 1);
      chk("w0_paddr_held", o_paddr, 32'h0000_0010);

      // read with 3 wait states, then response backpressure
      put_cmd('{write: 1'b0, addr: 32'h0000_0004, wdata: 32'h0});
      i_pready = 1'b0; i_prdata = 32'hDEAD_BEEF;
      tick();
      i_cmd_valid = 1'b0;
      chk("r3_pwrite", o_pwrite, 0);
      chk("r3_paddr", o_paddr, 32'h0000_0004);
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("r3_wait_penable", o_penable, 1);
         tick();
      end
      chk("r3_last_penable", o_penable, 1);
      i_pready = 1'b1;
      tick();
      i_pready = 1'b0;
      chk("r3_rsp_valid", o_rsp_valid, 1);
      chk("r3_rsp_rdata", o_rsp_rdata, 32'hDEAD_BEEF);
      chk("r3_rsp_err", o_rsp_err, 0);
      put_cmd('{write: 1'b1, addr: 32'h0000_0020, wdata: 32'h0000_0011});
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_rsp_valid", o_rsp_valid, 1);
         chk("bp_rsp_rdata", o_rsp_rdata, 32'hDEAD_BEEF);
         chk("bp_cmd_ready", o_cmd_ready, 0);
         chk("bp_psel", o_psel, 0);
      end
      i_rsp_ready = 1'b1;
      tick();
      i_rsp_ready = 1'b0;
      chk("bp_idle_ready", o_cmd_ready, 1);
      chk("bp_idle_rsp_valid", o_rsp_valid, 0);
      chk("bp_txn_cnt", o_txn_cnt, 2);
      chk("bp_not_accepted", o_paddr, 32'h0000_0004);
      tick();
      i_cmd_valid = 1'b0;
      chk("bp_accept_psel", o_psel, 1);
      chk("bp_accept_paddr", o_paddr, 32'h0000_0020);
      chk("bp_accept_pwdata", o_pwdata, 32'h0000_0011);
      i_pready = 1'b1;
      tick();
      tick();
      i_pready = 1'b0;
      chk("bp_w_rsp_valid", o_rsp_valid, 1);
      i_rsp_ready = 1'b1;
      tick();
      i_rsp_ready = 1'b0;
      chk("bp_w_txn_cnt", o_txn_cnt, 3);

      // pready on the timeout cycle wins
      put_cmd('{write: 1'b0, addr: 32'h0000_0040, wdata: 32'h0});
      i_prdata = 32'hCAFE_F00D;
      tick();
      i_cmd_valid = 1'b0;
      tick();
      for (int i = 0; i < 7; i++) begin
         chk("co_penable", o_penable, 1);
         tick();
      end
      chk("co_8th_penable", o_penable, 1);
      i_pready = 1'b1;
      tick();
      i_pready = 1'b0;
      chk("co_rsp_valid", o_rsp_valid, 1);
      chk("co_rsp_err", o_rsp_err, 0);
      chk("co_rsp_rdata", o_rsp_rdata, 32'hCAFE_F00D);
      i_rsp_ready = 1'b1;
      tick();
      i_rsp_ready = 1'b0;
      chk("co_txn_cnt", o_txn_cnt, 4);

      // timeout with pready stuck low
      put_cmd('{write: 1'b0, addr: 32'h0000_0030, wdata: 32'h0});
      tick();
      i_cmd_valid = 1'b0;
      tick();
      n_acc = 0;
      for (int i = 0; i < 20 && o_penable; i++) begin
         n_acc++;
         tick();
      end
      chk("to_access_cycles", n_acc, 8);
      chk("to_psel", o_psel, 0);
      chk("to_penable", o_penable, 0);
      chk("to_rsp_valid", o_rsp_valid, 1);
      chk("to_rsp_err", o_rsp_err, 1);
      chk("to_rsp_rdata", o_rsp_rdata, 0);
      i_rsp_ready = 1'b1;
      tick();
      i_rsp_ready = 1'b0;
      chk("to_txn_cnt", o_txn_cnt, 5);

      // asynchronous reset in the middle of ACCESS
      put_cmd('{write: 1'b1, addr: 32'h0000_0050, wdata: 32'h0000_0055});
      tick();
      i_cmd_valid = 1'b0;
      tick();
      chk("mr_penable_before", o_penable, 1);
      cnt_before = o_txn_cnt;
      chk("mr_cnt_before", cnt_before, 5);
      #2 rst = 1'b1;
      #1;
      chk("mr_psel", o_psel, 0);
      chk("mr_penable", o_penable, 0);
      chk("mr_rsp_valid", o_rsp_valid, 0);
      chk("mr_txn_cnt", o_txn_cnt, 0);
      tick();
      rst = 1'b0;
      tick();
      chk("mr_cmd_ready", o_cmd_ready, 1);
      chk("mr_rsp_after", o_rsp_valid, 0);

      // back-to-back writes, one transfer every 4 cycles
      put_cmd('{write: 1'b1, addr: 32'h0000_0100, wdata: 32'h0000_00B0});
      i_pready = 1'b1; i_rsp_ready = 1'b1;
      ns = 0;
      for (int c = 0; c < 20 && ns < 3; c++) begin
         tick();
         if (o_psel && !o_penable) begin
            setup_cyc[ns] = c;
            chk("b2b_paddr", o_paddr, 32'h0000_0100 + 32'(ns * 4));
            ns++;
            i_cmd_addr  = 32'h0000_0100 + 32'(ns * 4);
            i_cmd_wdata = 32'h0000_00B0 + 32'(ns);
            if (ns == 3) i_cmd_valid = 1'b0;
         end
      end
      chk("b2b_setups_seen", ns, 3);
      if (ns == 3) begin
         chk("b2b_gap01", setup_cyc[1] - setup_cyc[0], 4);
         chk("b2b_gap12", setup_cyc[2] - setup_cyc[1], 4);
      end
      for (int i = 0; i < 10 && o_txn_cnt != 16'd3; i++) tick();
      chk("b2b_txn_cnt", o_txn_cnt, 3);
      i_pready = 1'b0; i_rsp_ready = 1'b0; i_cmd_valid = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
